prbs_checker_8bit: RTL



---
 rtl/prbs_checker_8bit.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/prbs_checker_8bit.sv
// prbs_checker_8bit: receive-side checker for the 8-bit XNOR LFSR
// stream (taps 7,3,2,1). It self-synchronises, locks, then free-runs
// its own copy of the LFSR and counts bit errors.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   valid_i    bit_i carries a stream bit this cycle (one beat)
//   bit_i      received stream bit
//   clear_i    synchronous clear of the error (and bit) counters
//   locked_o   checker locked to the stream
//   err_o      one-cycle pulse: mismatch detected while locked
//   err_cnt_o  saturating count of mismatches while locked
//   bit_cnt_o  saturating count of beats checked while locked
//              (present only with PRBS_CHECKER_BIT_CNT_EN defined)
//
// Optional feature macro: PRBS_CHECKER_BIT_CNT_EN

module prbs_checker_8bit #(
  parameter int LOCK_CNT      = 16,
  parameter int UNLOCK_CNT    = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  input  logic                     bit_i,
  input  logic                     clear_i,
  output logic                     locked_o,
  output logic                     err_o,
`ifdef PRBS_CHECKER_BIT_CNT_EN
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic [31:0]              bit_cnt_o
`else
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
`endif
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);

  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
  localparam logic [UW-1:0] UNLK_V = UW'(UNLOCK_CNT);

  typedef enum logic [2:0] {
    FILL   = 3'b001,
    HUNT   = 3'b010,
    LOCKED = 3'b100
  } state_e;

  state_e state_q;
  state_e state_d;

  logic st_fill;
  logic st_hunt;
  logic st_lock;

  logic [7:0]    s_q;
  logic [7:0]    s_d;
  logic [2:0]    fill_q;
  logic [2:0]    fill_d;
  logic [MW-1:0] match_q;
  logic [MW-1:0] match_d;
  logic [MW-1:0] match_inc;
  logic [UW-1:0] miss_q;
  logic [UW-1:0] miss_d;
  logic [UW-1:0] miss_inc;

  logic beat;
  logic pred;
  logic mism;
  logic fill_done;
  logic lock_hit;
  logic unlock_hit;

  logic                     locked_q;
  logic                     locked_d;
  logic                     err_q;
  logic                     err_d;
  logic [ERR_CNT_WIDTH-1:0] ecnt_q;
  logic [ERR_CNT_WIDTH-1:0] ecnt_d;

  assign st_fill = (state_q == FILL);
  assign st_hunt = (state_q == HUNT);
  assign st_lock = (state_q == LOCKED);

  assign beat = valid_i;

  // XNOR feedback: all-ones is the lockup word, all-zeros is legal.
  assign pred = ~(s_q[7] ^ s_q[3] ^ s_q[2] ^ s_q[1]);
  assign mism = bit_i ^ pred;

  assign fill_done = (fill_q == 3'd7);
  assign match_inc = match_q + 1'b1;
  assign miss_inc  = miss_q + 1'b1;

  assign lock_hit   = ~mism & (match_inc == LOCK_V);
  assign unlock_hit = mism & (miss_inc == UNLK_V);

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (beat) begin
      unique case (1'b1)
        st_fill: if (fill_done)  state_d = HUNT;
        st_hunt: if (lock_hit)   state_d = LOCKED;
        st_lock: if (unlock_hit) state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  // shift register and fill/match/miss counters
  always_comb begin
    s_d     = s_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    if (beat) begin
      unique case (1'b1)
        st_fill: begin
          s_d     = {s_q[6:0], bit_i};
          fill_d  = fill_done ? 3'd0 : fill_q + 3'd1;
          match_d = '0;
        end
        st_hunt: begin
          s_d     = {s_q[6:0], bit_i};
          match_d = mism ? '0 : match_inc;
        end
        st_lock: begin
          // Free-run: a corrupted input bit never enters s.
          s_d    = {s_q[6:0], pred};
          miss_d = (mism && !unlock_hit) ? miss_inc : '0;
          if (unlock_hit) begin
            fill_d  = '0;
            match_d = '0;
          end
        end
        default: begin
          fill_d  = '0;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  // output logic
  always_comb begin
    locked_d = (state_d == LOCKED);
    err_d    = beat & st_lock & mism;
    ecnt_d   = ecnt_q;
    if (clear_i) begin
      ecnt_d = '0;
    end else if (err_d && !(&ecnt_q)) begin
      ecnt_d = ecnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q      <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      s_q      <= s_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign err_cnt_o = ecnt_q;

`ifdef PRBS_CHECKER_BIT_CNT_EN
  logic [31:0] bcnt_q;
  logic [31:0] bcnt_d;

  always_comb begin
    bcnt_d = bcnt_q;
    if (clear_i) begin
      bcnt_d = '0;
    end else if (beat && st_lock && !(&bcnt_q)) begin
      bcnt_d = bcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  assign bit_cnt_o = bcnt_q;
`endif

endmodule
